// File: rtl/kyber_pkg.sv
// Shared ML-KEM parameters, the polynomial bank slot map, and the 12-bit to byte packing helper.
// Used by every stage that moves coefficients between the bank and byte streams.
package kyber_pkg;

    localparam int KYBER_N     = 256;
    localparam int KYBER_Q     = 3329;
    localparam int KYBER_K     = 3;
    localparam int SLOT_W      = 5;
    localparam int COEF_W      = 12;
    localparam int SLOT_T_HAT0 = 0;
    localparam int STRIDE      = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_CAP1,
        ST_OUT0,
        ST_OUT1,
        ST_OUT2,
        ST_FIN
    } enc_state_t;

    // Byte idx of the little-endian 24-bit word {c1, c0}.
    function automatic logic [7:0] pack12to8(input logic [COEF_W-1:0] c0,
                                             input logic [COEF_W-1:0] c1,
                                             input logic [1:0]        idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = c0[7:0];
            2'd1:    b = {c1[3:0], c0[11:8]};
            default: b = c1[11:4];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ek_encode12.sv
// Reads the t_hat polynomials from the bank and streams them as ByteEncode12 bytes.
// Six cycles per coefficient pair with ready held high; each output byte holds until its handshake.
module ek_encode12
    import kyber_pkg::*;
#(
    parameter int NUM_POLYS   = KYBER_K,
    parameter int SLOT_BASE   = SLOT_T_HAT0,
    parameter int SLOT_STRIDE = STRIDE,
    parameter int Q           = KYBER_Q
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err_range,
    output logic [SLOT_W-1:0] o_mem_slot,
    output logic [7:0]        o_mem_addr,
    input  logic [COEF_W-1:0] i_mem_dout,
    output logic              o_byte_valid,
    output logic [7:0]        o_byte_data,
    input  logic              i_byte_ready
);

    localparam int P_W   = (NUM_POLYS > 1) ? $clog2(NUM_POLYS) : 1;
    localparam int PAIRS = KYBER_N / 2;

    enc_state_t        r_state;
    enc_state_t        w_state_nxt;
    logic [6:0]        r_k;
    logic [P_W-1:0]    r_p;
    logic [SLOT_W-1:0] r_slot;
    logic [7:0]        r_addr;
    logic [COEF_W-1:0] r_c0;
    logic [COEF_W-1:0] r_c1;
    logic              r_err;
    logic              r_byte_valid;
    logic [7:0]        r_byte_data;
    logic              w_hs;
    logic              w_last_pair;
    logic              w_oob;
    logic [6:0]        w_k_inc;

    assign w_hs        = r_byte_valid && i_byte_ready;
    assign w_last_pair = (r_k == 7'(PAIRS - 1)) && (r_p == P_W'(NUM_POLYS - 1));
    assign w_oob       = (32'(i_mem_dout) >= Q);
    assign w_k_inc     = r_k + 7'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_state_nxt = ST_RD0;
            ST_RD0:  w_state_nxt = ST_RD1;
            ST_RD1:  w_state_nxt = ST_CAP1;
            ST_CAP1: w_state_nxt = ST_OUT0;
            ST_OUT0: if (w_hs) w_state_nxt = ST_OUT1;
            ST_OUT1: if (w_hs) w_state_nxt = ST_OUT2;
            ST_OUT2: if (w_hs) w_state_nxt = w_last_pair ? ST_FIN : ST_RD0;
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state != ST_IDLE) && (r_state != ST_FIN);
        o_done = (r_state == ST_FIN);
    end

    // Address registers are loaded one edge early so they are on the bus during RD0/RD1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_k          <= '0;
            r_p          <= '0;
            r_slot       <= SLOT_W'(SLOT_BASE);
            r_addr       <= '0;
            r_c0         <= '0;
            r_c1         <= '0;
            r_err        <= 1'b0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
        end else begin
            r_byte_valid <= (w_state_nxt == ST_OUT0) || (w_state_nxt == ST_OUT1) ||
                            (w_state_nxt == ST_OUT2);
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_k    <= '0;
                        r_p    <= '0;
                        r_slot <= SLOT_W'(SLOT_BASE);
                        r_addr <= '0;
                        r_err  <= 1'b0;
                    end
                end
                ST_RD0: r_addr <= {r_k, 1'b1};
                ST_RD1: begin
                    r_c0 <= i_mem_dout;
                    if (w_oob) r_err <= 1'b1;
                end
                ST_CAP1: begin
                    r_c1        <= i_mem_dout;
                    if (w_oob) r_err <= 1'b1;
                    r_byte_data <= pack12to8(r_c0, i_mem_dout, 2'd0);
                end
                ST_OUT0: if (w_hs) r_byte_data <= pack12to8(r_c0, r_c1, 2'd1);
                ST_OUT1: if (w_hs) r_byte_data <= pack12to8(r_c0, r_c1, 2'd2);
                ST_OUT2: begin
                    if (w_hs && !w_last_pair) begin
                        r_k    <= w_k_inc;
                        r_addr <= {w_k_inc, 1'b0};
                        if (r_k == 7'(PAIRS - 1)) begin
                            r_p    <= r_p + 1'b1;
                            r_slot <= r_slot + SLOT_W'(SLOT_STRIDE);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_err_range  = r_err;
    assign o_mem_slot   = r_slot;
    assign o_mem_addr   = r_addr;
    assign o_byte_valid = r_byte_valid;
    assign o_byte_data  = r_byte_data;

endmodule

// File: tb/tb_ek_encode12.sv
// Drives ek_encode12 from a modelled polynomial bank and compares the byte stream with a
// ByteEncode12 reference built from the bank contents.
module tb_ek_encode12;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        err_range;
    logic [4:0]  mem_slot;
    logic [7:0]  mem_addr;
    logic [11:0] mem_dout;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready = 1'b1;

    logic [11:0] bank [0:31][0:255];
    logic [7:0]  got [$];
    logic [7:0]  exp_q [$];
    int          n_checks = 0;
    int          n_errs = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          start_cyc = 0;
    int          stall_viol = 0;
    logic        rand_ready = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    ek_encode12 dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .o_busy      (busy),
        .o_done      (done),
        .o_err_range (err_range),
        .o_mem_slot  (mem_slot),
        .o_mem_addr  (mem_addr),
        .i_mem_dout  (mem_dout),
        .o_byte_valid(byte_valid),
        .o_byte_data (byte_data),
        .i_byte_ready(byte_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        mem_dout <= bank[mem_slot][mem_addr];
    end

    always @(posedge clk) begin
        #1;
        byte_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (byte_valid && byte_ready) got.push_back(byte_data);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!byte_valid || byte_data != prev_data)) stall_viol++;
            prev_stall = byte_valid && !byte_ready;
            prev_data  = byte_data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
        end
    endtask

    // Reference: each pair forms the 24-bit value c0 + 4096*c1, emitted least significant byte first.
    task automatic build_exp(output logic any_oob);
        int v;
        exp_q.delete();
        any_oob = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 256; i += 2) begin
                v = int'(bank[3*p][i]) + 4096 * int'(bank[3*p][i+1]);
                exp_q.push_back(8'(v % 256));
                exp_q.push_back(8'((v / 256) % 256));
                exp_q.push_back(8'(v / 65536));
                if (bank[3*p][i] >= 12'd3329 || bank[3*p][i+1] >= 12'd3329) any_oob = 1'b1;
            end
        end
    endtask

    task automatic compare_stream(input string tag);
        int nmis = 0;
        check_eq({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) nmis++;
        check_eq({tag, "_bytes_mismatched"}, nmis, 0);
    endtask

    task automatic fill_random();
        for (int s = 0; s < 32; s++)
            for (int i = 0; i < 256; i++)
                bank[s][i] = 12'($urandom_range(0, 3328));
    endtask

    task automatic do_start();
        @(posedge clk);
        #1;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input logic pulse, output logic ok);
        int d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(posedge clk);
            #1;
            if (pulse) start = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            #1;
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int max_cyc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #1;
            if (got.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        logic ok;
        logic oob;
        int   d0;

        for (int s = 0; s < 32; s++)
            for (int i = 0; i < 256; i++)
                bank[s][i] = 12'h000;

        // Reset held for two edges with a simultaneous start request
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err_range, 0);
        check_eq("rst_valid", byte_valid, 0);
        check_eq("rst_data", byte_data, 0);
        check_eq("rst_slot", mem_slot, 0);
        check_eq("rst_addr", mem_addr, 0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_start_ignored_busy", busy, 0);
        check_eq("rst_start_ignored_valid", byte_valid, 0);

        // Ramp pattern, ready held high
        for (int p = 0; p < 3; p++)
            for (int i = 0; i < 256; i++)
                bank[3*p][i] = 12'(i);
        build_exp(oob);
        got.delete();
        do_start();
        wait_done(5000, 1'b0, ok);
        check_eq("ramp_done_seen", ok, 1);
        check_eq("ramp_done_latency", done_cyc - start_cyc, 2305);
        compare_stream("ramp");
        if (got.size() >= 6) begin
            check_eq("ramp_b0", got[0], 8'h00);
            check_eq("ramp_b1", got[1], 8'h10);
            check_eq("ramp_b2", got[2], 8'h00);
            check_eq("ramp_b3", got[3], 8'h02);
            check_eq("ramp_b4", got[4], 8'h30);
            check_eq("ramp_b5", got[5], 8'h00);
        end else begin
            check_eq("ramp_short", got.size(), 1152);
        end
        check_eq("ramp_err", err_range, 0);
        @(negedge clk);
        check_eq("ramp_busy_after", busy, 0);

        // Packing of one known pair
        bank[0][0] = 12'h123;
        bank[0][1] = 12'h456;
        build_exp(oob);
        got.delete();
        do_start();
        wait_done(5000, 1'b0, ok);
        check_eq("pack_done_seen", ok, 1);
        if (got.size() >= 3) begin
            check_eq("pack_b0", got[0], 8'h23);
            check_eq("pack_b1", got[1], 8'h61);
            check_eq("pack_b2", got[2], 8'h45);
        end else begin
            check_eq("pack_short", got.size(), 1152);
        end
        compare_stream("pack");

        // Random data with random backpressure
        fill_random();
        build_exp(oob);
        got.delete();
        stall_viol = 0;
        rand_ready = 1'b1;
        do_start();
        wait_done(20000, 1'b0, ok);
        rand_ready = 1'b0;
        check_eq("bp_done_seen", ok, 1);
        compare_stream("bp");
        check_eq("bp_stall_violations", stall_viol, 0);
        check_eq("bp_err", err_range, oob);

        // Out-of-range coefficient in the second polynomial
        fill_random();
        bank[3][17] = 12'd3329;
        build_exp(oob);
        got.delete();
        do_start();
        wait_bytes(300, 5000, ok);
        check_eq("range_reach_300", ok, 1);
        check_eq("range_err_before", err_range, 0);
        wait_done(5000, 1'b0, ok);
        check_eq("range_done_seen", ok, 1);
        check_eq("range_err_after", err_range, 1);
        check_eq("range_err_model", err_range, oob);
        compare_stream("range");
        if (got.size() >= 411) check_eq("range_b410", got[410], 8'hD0);
        bank[3][17] = 12'd100;
        do_start();
        @(negedge clk);
        check_eq("range_err_cleared", err_range, 0);
        wait_done(5000, 1'b0, ok);
        check_eq("range_err_stays_clear", err_range, 0);

        // Abort by reset mid-stream, then restart with start pulses during the run
        fill_random();
        build_exp(oob);
        got.delete();
        do_start();
        wait_bytes(500, 5000, ok);
        check_eq("abort_reach_500", ok, 1);
        d0 = done_cnt;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_valid", byte_valid, 0);
        repeat (20) @(negedge clk);
        check_eq("abort_no_done", done_cnt, d0);
        got.delete();
        do_start();
        wait_done(5000, 1'b1, ok);
        check_eq("restart_done_seen", ok, 1);
        check_eq("restart_single_done", done_cnt, d0 + 1);
        compare_stream("restart");
        repeat (5) @(negedge clk);
        check_eq("restart_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
